// File: rtl/dm_msg_dispatch_pkg.sv
// Shared constants for the dot-matrix message dispatcher: opcodes, FSM states
// and the matrix geometry defaults shared with the DotController and RX decoder.
package dm_msg_dispatch_pkg;

  localparam int DM_NUM_COLS   = 5;
  localparam int DM_ROW_W      = 7;
  localparam int DM_COL_ADDR_W = 5;

  localparam logic [7:0] OP_WRITE   = 8'h01;
  localparam logic [7:0] OP_FILL    = 8'h02;
  localparam logic [7:0] OP_CLEAR   = 8'h03;
  localparam logic [7:0] OP_PAIR    = 8'h04;
  localparam logic [7:0] OP_ENABLE  = 8'h05;
  localparam logic [7:0] OP_DISABLE = 8'h06;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

endpackage

// File: rtl/dm_msg_dispatch_sat_cnt8.sv
// 8-bit up-counter that sticks at 255; used for the debug error/drop counters.
module dm_msg_dispatch_sat_cnt8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/dm_msg_dispatch.sv
// Turns decoded 4-byte UART messages into column writes for the dot-matrix
// controller. States: IDLE wait msg | DECODE validate | WRITE strobe | GAP pause.
module dm_msg_dispatch
  import dm_msg_dispatch_pkg::*;
#(
  parameter int NUM_COLS   = DM_NUM_COLS,
  parameter int ROW_W      = DM_ROW_W,
  parameter int COL_ADDR_W = DM_COL_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           msg,
  input  logic                  msg_ready,
  output logic                  busy,
  output logic                  dm_write,
  output logic                  dm_enable,
  output logic [COL_ADDR_W-1:0] dm_col_addr,
  output logic [ROW_W-1:0]      dm_row_in,
  output logic [7:0]            err_cnt,
  output logic [7:0]            drop_cnt
);

  localparam logic [7:0] NUM_COLS8 = 8'(NUM_COLS);
  localparam logic [8:0] NUM_COLS9 = 9'(NUM_COLS);

  state_t state, state_d;
  logic [7:0] op_q, op_d, b1_q, b1_d;
  logic [ROW_W-1:0] ra_q, ra_d, rb_q, rb_d;
  logic busy_d, write_d, enable_d, err_inc, drop_inc, wr_start, more;
  logic [COL_ADDR_W-1:0] col_d;
  logic [ROW_W-1:0] row_d;
  logic [7:0] col8;
  logic [8:0] pair_hi;
  logic unused_msg_bits;

  // Row bits above ROW_W in bytes 2 and 3 carry no information.
  assign unused_msg_bits = &{1'b0, msg[15], msg[7]};

  assign col8     = 8'(dm_col_addr);
  // 9-bit so that byte1 = 0xFF cannot wrap around to column 0.
  assign pair_hi  = {1'b0, b1_q} + 9'd1;
  assign more     = (((op_q == OP_FILL) || (op_q == OP_CLEAR)) && (col8 < NUM_COLS8 - 8'd1)) ||
                    ((op_q == OP_PAIR) && (col8 == b1_q));
  assign drop_inc = msg_ready && (state != ST_IDLE);

  always_comb begin
    state_d  = state;
    busy_d   = busy;
    write_d  = 1'b0;
    enable_d = dm_enable;
    col_d    = dm_col_addr;
    row_d    = dm_row_in;
    op_d     = op_q;
    b1_d     = b1_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    err_inc  = 1'b0;
    wr_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (msg_ready) begin
          op_d    = msg[31:24];
          b1_d    = msg[23:16];
          ra_d    = msg[8 +: ROW_W];
          rb_d    = msg[0 +: ROW_W];
          state_d = ST_DECODE;
          busy_d  = 1'b1;
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        case (op_q)
          OP_WRITE: begin
            if (b1_q < NUM_COLS8) begin
              wr_start = 1'b1;
              col_d    = b1_q[COL_ADDR_W-1:0];
              row_d    = ra_q;
            end else begin
              err_inc = 1'b1;
            end
          end
          OP_FILL: begin
            wr_start = 1'b1;
            col_d    = '0;
            row_d    = ra_q;
          end
          OP_CLEAR: begin
            wr_start = 1'b1;
            col_d    = '0;
            row_d    = '0;
          end
          OP_PAIR: begin
            if (pair_hi < NUM_COLS9) begin
              wr_start = 1'b1;
              col_d    = b1_q[COL_ADDR_W-1:0];
              row_d    = ra_q;
            end else begin
              err_inc = 1'b1;
            end
          end
          OP_ENABLE:  enable_d = 1'b1;
          OP_DISABLE: enable_d = 1'b0;
          default:    err_inc = 1'b1;
        endcase
        if (wr_start) begin
          state_d  = ST_WRITE;
          busy_d   = 1'b1;
          write_d  = 1'b1;
          enable_d = 1'b1;
        end
      end
      ST_WRITE: state_d = ST_GAP;
      ST_GAP: begin
        if (more) begin
          state_d = ST_WRITE;
          write_d = 1'b1;
          col_d   = dm_col_addr + COL_ADDR_W'(1);
          // FILL/CLEAR keep the same row pattern for every column.
          if (op_q == OP_PAIR) row_d = rb_q;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      dm_write    <= 1'b0;
      dm_enable   <= 1'b0;
      dm_col_addr <= '0;
      dm_row_in   <= '0;
      op_q        <= 8'd0;
      b1_q        <= 8'd0;
      ra_q        <= '0;
      rb_q        <= '0;
    end else begin
      state       <= state_d;
      busy        <= busy_d;
      dm_write    <= write_d;
      dm_enable   <= enable_d;
      dm_col_addr <= col_d;
      dm_row_in   <= row_d;
      op_q        <= op_d;
      b1_q        <= b1_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
    end
  end

  dm_msg_dispatch_sat_cnt8 u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .count (err_cnt)
  );

  dm_msg_dispatch_sat_cnt8 u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

endmodule

// File: tb/tb_dm_msg_dispatch.sv
// Bench for dm_msg_dispatch: directed scenarios with literal expectations plus
// random traffic, all cross-checked every cycle against a transaction-level model.
module tb_dm_msg_dispatch;

  localparam int N = 5;
  localparam int K_WR = 0, K_EN = 1, K_DIS = 2, K_ERR = 3, K_BLO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        msg_ready = 1'b0;
  logic [31:0] msg = 32'd0;
  logic        busy, dm_write, dm_enable;
  logic [4:0]  dm_col_addr;
  logic [6:0]  dm_row_in;
  logic [7:0]  err_cnt, drop_cnt;

  dm_msg_dispatch dut (
    .clk         (clk),
    .reset       (reset),
    .msg         (msg),
    .msg_ready   (msg_ready),
    .busy        (busy),
    .dm_write    (dm_write),
    .dm_enable   (dm_enable),
    .dm_col_addr (dm_col_addr),
    .dm_row_in   (dm_row_in),
    .err_cnt     (err_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  // Model: each accepted message becomes a list of timed effects.
  typedef struct {
    int edge_n;
    int kind;
    int col;
    int row;
  } eff_t;

  eff_t effq[$];
  eff_t keepq[$];
  int   cyc = 0;
  int   idle_from = 0;
  bit   model_on = 1'b0;
  int   e_busy, e_write, e_en, e_col, e_row, e_err, e_drop;

  function automatic void sched(input int ed, input int k, input int c, input int r);
    eff_t e;
    e.edge_n = ed;
    e.kind   = k;
    e.col    = c;
    e.row    = r;
    effq.push_back(e);
  endfunction

  function automatic void accept(input logic [31:0] m);
    int op, b1, r2, r3;
    int cols[$];
    int rows[$];
    bit bad;
    op  = int'(m[31:24]);
    b1  = int'(m[23:16]);
    r2  = int'(m[14:8]);
    r3  = int'(m[6:0]);
    bad = 1'b0;
    case (op)
      1: if (b1 < N) begin cols.push_back(b1); rows.push_back(r2); end else bad = 1'b1;
      2: for (int i = 0; i < N; i++) begin cols.push_back(i); rows.push_back(r2); end
      3: for (int i = 0; i < N; i++) begin cols.push_back(i); rows.push_back(0); end
      4: if (b1 + 1 < N) begin
           cols.push_back(b1);     rows.push_back(r2);
           cols.push_back(b1 + 1); rows.push_back(r3);
         end else bad = 1'b1;
      5: sched(cyc + 1, K_EN, 0, 0);
      6: sched(cyc + 1, K_DIS, 0, 0);
      default: bad = 1'b1;
    endcase
    e_busy = 1;
    if (bad) sched(cyc + 1, K_ERR, 0, 0);
    if (cols.size() > 0) sched(cyc + 1, K_EN, 0, 0);
    foreach (cols[k]) sched(cyc + 1 + 2 * k, K_WR, cols[k], rows[k]);
    idle_from = cyc + 2 + 2 * cols.size();
    sched(idle_from - 1, K_BLO, 0, 0);
  endfunction

  always @(posedge clk) begin
    cyc++;
    e_write = 0;
    if (reset) begin
      effq.delete();
      model_on  = 1'b1;
      e_busy    = 0;
      e_en      = 0;
      e_col     = 0;
      e_row     = 0;
      e_err     = 0;
      e_drop    = 0;
      idle_from = cyc + 1;
    end else if (model_on) begin
      keepq.delete();
      foreach (effq[i]) begin
        if (effq[i].edge_n == cyc) begin
          case (effq[i].kind)
            K_WR:  begin e_write = 1; e_col = effq[i].col; e_row = effq[i].row; end
            K_EN:  e_en = 1;
            K_DIS: e_en = 0;
            K_ERR: e_err = (e_err < 255) ? e_err + 1 : 255;
            K_BLO: e_busy = 0;
            default: ;
          endcase
        end else begin
          keepq.push_back(effq[i]);
        end
      end
      effq = keepq;
      if (msg_ready) begin
        if (cyc < idle_from) e_drop = (e_drop < 255) ? e_drop + 1 : 255;
        else accept(msg);
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("busy",     int'(busy),        e_busy);
      chk("dm_write", int'(dm_write),    e_write);
      chk("dm_en",    int'(dm_enable),   e_en);
      chk("col_addr", int'(dm_col_addr), e_col);
      chk("row_in",   int'(dm_row_in),   e_row);
      chk("err_cnt",  int'(err_cnt),     e_err);
      chk("drop_cnt", int'(drop_cnt),    e_drop);
    end
  end

  int wr_seen = 0;
  always @(posedge clk) begin
    #1;
    if (dm_write === 1'b1) wr_seen++;
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] m);
    msg       = m;
    msg_ready = 1'b1;
    @(negedge clk);
    msg_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_msg();
    int sel;
    logic [7:0] op, b1;
    logic [15:0] r;
    sel = $urandom_range(0, 9);
    if (sel <= 5) op = 8'(sel + 1);
    else if (sel == 6) op = 8'h00;
    else op = 8'($urandom_range(7, 255));
    if ($urandom_range(0, 7) == 0) b1 = 8'hFF;
    else b1 = 8'($urandom_range(0, 6));
    r = 16'($urandom());
    return {op, b1, r};
  endfunction

  initial begin
    int bc, wc, w0;
    step(3);
    reset = 1'b0;
    chk("rst_busy",  int'(busy), 0);
    chk("rst_write", int'(dm_write), 0);
    chk("rst_en",    int'(dm_enable), 0);
    chk("rst_err",   int'(err_cnt), 0);
    chk("rst_drop",  int'(drop_cnt), 0);

    // single WRITE
    send(32'h01025500);
    chk("t1_busy_e0", int'(busy), 1);
    chk("t1_wr_e0", int'(dm_write), 0);
    step();
    chk("t1_wr_e1", int'(dm_write), 1);
    chk("t1_col", int'(dm_col_addr), 2);
    chk("t1_row", int'(dm_row_in), 'h55);
    chk("t1_en", int'(dm_enable), 1);
    step();
    chk("t1_wr_e2", int'(dm_write), 0);
    chk("t1_busy_e2", int'(busy), 1);
    step();
    chk("t1_busy_e3", int'(busy), 0);
    step();

    // FILL
    bc = 0;
    wc = 0;
    send(32'h02007F00);
    for (int i = 0; i < 12; i++) begin
      if (busy === 1'b1) bc++;
      if (dm_write === 1'b1) begin
        chk("t2_col", int'(dm_col_addr), wc);
        chk("t2_row", int'(dm_row_in), 'h7F);
        wc++;
      end
      step();
    end
    chk("t2_busy_cycles", bc, 11);
    chk("t2_writes", wc, 5);

    // rejected messages
    w0 = wr_seen;
    send(32'h04041122);
    step();
    chk("t3_busy_after_decode", int'(busy), 0);
    send(32'h01070000);
    step();
    send(32'h09AABBCC);
    step();
    chk("t3_err", int'(err_cnt), 3);
    chk("t3_no_writes", wr_seen - w0, 0);

    // drops during FILL, including the GAP->IDLE edge
    w0 = wr_seen;
    send(32'h02001500);
    step(2);
    send(32'h01000100);
    step(7);
    send(32'h01000100);
    chk("t4_busy_done", int'(busy), 0);
    step(2);
    chk("t4_drop", int'(drop_cnt), 2);
    chk("t4_writes", wr_seen - w0, 5);
    chk("t4_last_col", int'(dm_col_addr), 4);

    // reset during the third FILL write
    send(32'h02002A00);
    step(5);
    chk("t5_third_wr", int'(dm_write), 1);
    chk("t5_third_col", int'(dm_col_addr), 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_write", int'(dm_write), 0);
    chk("t5_en", int'(dm_enable), 0);
    chk("t5_col", int'(dm_col_addr), 0);
    chk("t5_row", int'(dm_row_in), 0);
    chk("t5_err", int'(err_cnt), 0);
    chk("t5_drop", int'(drop_cnt), 0);
    w0 = wr_seen;
    step(12);
    chk("t5_no_writes", wr_seen - w0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 399) == 0);
      msg_ready = ($urandom_range(0, 2) == 0);
      msg       = rand_msg();
      step();
    end
    reset     = 1'b1;
    msg_ready = 1'b0;
    step();
    reset = 1'b0;

    // error counter saturation, then enable/disable
    for (int i = 0; i < 300; i++) begin
      send({8'($urandom_range(7, 255)), 24'($urandom())});
      step();
    end
    chk("t6_err_sat", int'(err_cnt), 255);
    send(32'h01000100);
    step(4);
    chk("t6_en_on", int'(dm_enable), 1);
    send(32'h06000000);
    step();
    chk("t6_disable", int'(dm_enable), 0);
    send(32'h05000000);
    step();
    chk("t6_enable", int'(dm_enable), 1);

    // drop counter saturation under continuous msg_ready
    msg       = 32'h02000000;
    msg_ready = 1'b1;
    step(800);
    msg_ready = 1'b0;
    step(12);
    chk("t7_drop_sat", int'(drop_cnt), 255);
    chk("t7_err_hold", int'(err_cnt), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
